conv2d_loop_scheduler: RTL and testbench

//  Sequences one conv2d layer on a single shared MAC datapath. Walks the output

---
 rtl/conv2d_loop_scheduler_if.sv | 38 +++
 rtl/conv2d_loop_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_conv2d_loop_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_loop_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_loop_scheduler_if
//  Purpose  : Control, MAC-term and output-write signals of the conv2d scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface conv2d_loop_scheduler_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  mac_ready;
  logic                  mac_valid;
  logic                  mac_clear;
  logic                  mac_last;
  logic                  pad_zero;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  out_wr;
  logic [ADDR_WIDTH-1:0] out_addr;

  // Scheduler side
  modport master (
    input  start, mac_ready,
    output busy, done, mac_valid, mac_clear, mac_last, pad_zero,
           in_addr, w_addr, b_addr, out_wr, out_addr
  );

  // Layer control + memories/MAC side
  modport slave (
    output start, mac_ready,
    input  busy, done, mac_valid, mac_clear, mac_last, pad_zero,
           in_addr, w_addr, b_addr, out_wr, out_addr
  );
endinterface
`default_nettype wire

// File: rtl/conv2d_loop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_loop_scheduler
//  Purpose  : Walks one conv2d layer term by term on a shared MAC, issuing
//             operand addresses, padding flags, MAC controls and output writes.
//  Revision : 1.0 - initial release
// ============================================================================
module conv2d_loop_scheduler #(
  parameter int IN_CHANNELS  = 8,
  parameter int OUT_CHANNELS = 32,
  parameter int IN_HEIGHT    = 7,
  parameter int IN_WIDTH     = 7,
  parameter int KERNEL_SIZE  = 7,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 3,
  parameter int MAC_LATENCY  = 2,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  conv2d_loop_scheduler_if.master   bus
);

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OUT_HEIGHT = (IN_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH  + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;

  localparam int OC_W = cnt_w(OUT_CHANNELS);
  localparam int OH_W = cnt_w(OUT_HEIGHT);
  localparam int OW_W = cnt_w(OUT_WIDTH);
  localparam int IC_W = cnt_w(IN_CHANNELS);
  localparam int K_W  = cnt_w(KERNEL_SIZE);
  localparam int DR_W = cnt_w(MAC_LATENCY);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [OC_W-1:0] oc_q, oc_d;
  logic [OH_W-1:0] oh_q, oh_d;
  logic [OW_W-1:0] ow_q, ow_d;
  logic [IC_W-1:0] ic_q, ic_d;
  logic [K_W-1:0]  kh_q, kh_d;
  logic [K_W-1:0]  kw_q, kw_d;
  logic [DR_W-1:0] drain_q, drain_d;

  logic                  mac_valid_q, mac_valid_d;
  logic                  mac_clear_q, mac_clear_d;
  logic                  mac_last_q, mac_last_d;
  logic                  pad_zero_q, pad_zero_d;
  logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;

  logic [MAC_LATENCY-1:0] wr_v_q, wr_v_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q [MAC_LATENCY];
  logic [ADDR_WIDTH-1:0]  wr_addr_d [MAC_LATENCY];

  logic accept;
  logic kw_end, kh_end, ic_end, ow_end, oh_end, oc_end;
  logic elem_last, layer_last;
  logic run_nx, pad_nx;
  int   ih_nx, iw_nx, in_lin, w_lin, out_lin;

  assign accept     = mac_valid_q & bus.mac_ready;
  assign kw_end     = (int'(kw_q) == KERNEL_SIZE - 1);
  assign kh_end     = (int'(kh_q) == KERNEL_SIZE - 1);
  assign ic_end     = (int'(ic_q) == IN_CHANNELS - 1);
  assign ow_end     = (int'(ow_q) == OUT_WIDTH - 1);
  assign oh_end     = (int'(oh_q) == OUT_HEIGHT - 1);
  assign oc_end     = (int'(oc_q) == OUT_CHANNELS - 1);
  assign elem_last  = ic_end & kh_end & kw_end;
  assign layer_last = elem_last & ow_end & oh_end & oc_end;

  // Control FSM and loop nest; counters hold the term currently presented.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    oc_d    = oc_q;
    oh_d    = oh_q;
    ow_d    = ow_q;
    ic_d    = ic_q;
    kh_d    = kh_q;
    kw_d    = kw_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          oc_d = '0; oh_d = '0; ow_d = '0;
          ic_d = '0; kh_d = '0; kw_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (layer_last) begin
            state_d = S_DRAIN;
            drain_d = '0;
            oc_d = '0; oh_d = '0; ow_d = '0;
            ic_d = '0; kh_d = '0; kw_d = '0;
          end else if (!kw_end) begin
            kw_d = kw_q + 1'b1;
          end else begin
            kw_d = '0;
            if (!kh_end) begin
              kh_d = kh_q + 1'b1;
            end else begin
              kh_d = '0;
              if (!ic_end) begin
                ic_d = ic_q + 1'b1;
              end else begin
                ic_d = '0;
                if (!ow_end) begin
                  ow_d = ow_q + 1'b1;
                end else begin
                  ow_d = '0;
                  if (!oh_end) begin
                    oh_d = oh_q + 1'b1;
                  end else begin
                    oh_d = '0;
                    oc_d = oc_q + 1'b1;
                  end
                end
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (int'(drain_q) == MAC_LATENCY - 1) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Term outputs are decoded from the next counter values and registered,
  // so mac_ready only reaches them through the counter update.
  always_comb begin
    run_nx = (state_d == S_RUN);
    ih_nx  = int'(oh_d) * STRIDE + int'(kh_d) - PADDING;
    iw_nx  = int'(ow_d) * STRIDE + int'(kw_d) - PADDING;
    pad_nx = (ih_nx < 0) || (ih_nx >= IN_HEIGHT) || (iw_nx < 0) || (iw_nx >= IN_WIDTH);
    in_lin = (int'(ic_d) * IN_HEIGHT + ih_nx) * IN_WIDTH + iw_nx;
    w_lin  = ((int'(oc_d) * IN_CHANNELS + int'(ic_d)) * KERNEL_SIZE + int'(kh_d))
             * KERNEL_SIZE + int'(kw_d);

    mac_valid_d = run_nx;
    mac_clear_d = run_nx && (ic_d == '0) && (kh_d == '0) && (kw_d == '0);
    mac_last_d  = run_nx && (int'(ic_d) == IN_CHANNELS - 1)
                         && (int'(kh_d) == KERNEL_SIZE - 1)
                         && (int'(kw_d) == KERNEL_SIZE - 1);
    pad_zero_d  = run_nx && pad_nx;
    in_addr_d   = (run_nx && !pad_nx) ? ADDR_WIDTH'(in_lin) : '0;
    w_addr_d    = run_nx ? ADDR_WIDTH'(w_lin) : '0;
    b_addr_d    = run_nx ? ADDR_WIDTH'(int'(oc_d)) : '0;
  end

  // Write delay line: one slot per MAC pipeline stage so back-to-back
  // element completions never collide.
  always_comb begin
    out_lin      = (int'(oc_q) * OUT_HEIGHT + int'(oh_q)) * OUT_WIDTH + int'(ow_q);
    wr_v_d       = wr_v_q;
    wr_addr_d    = wr_addr_q;
    wr_v_d[0]    = accept & mac_last_q;
    wr_addr_d[0] = ADDR_WIDTH'(out_lin);
    for (int i = 1; i < MAC_LATENCY; i++) begin
      wr_v_d[i]    = wr_v_q[i-1];
      wr_addr_d[i] = wr_addr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      oc_q        <= '0;
      oh_q        <= '0;
      ow_q        <= '0;
      ic_q        <= '0;
      kh_q        <= '0;
      kw_q        <= '0;
      mac_valid_q <= 1'b0;
      mac_clear_q <= 1'b0;
      mac_last_q  <= 1'b0;
      pad_zero_q  <= 1'b0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
      wr_v_q      <= '0;
      for (int i = 0; i < MAC_LATENCY; i++) begin
        wr_addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      oc_q        <= oc_d;
      oh_q        <= oh_d;
      ow_q        <= ow_d;
      ic_q        <= ic_d;
      kh_q        <= kh_d;
      kw_q        <= kw_d;
      mac_valid_q <= mac_valid_d;
      mac_clear_q <= mac_clear_d;
      mac_last_q  <= mac_last_d;
      pad_zero_q  <= pad_zero_d;
      in_addr_q   <= in_addr_d;
      w_addr_q    <= w_addr_d;
      b_addr_q    <= b_addr_d;
      wr_v_q      <= wr_v_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac_clear = mac_clear_q;
  assign bus.mac_last  = mac_last_q;
  assign bus.pad_zero  = pad_zero_q;
  assign bus.in_addr   = in_addr_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.b_addr    = b_addr_q;
  assign bus.out_wr    = wr_v_q[MAC_LATENCY-1];
  assign bus.out_addr  = wr_v_q[MAC_LATENCY-1] ? wr_addr_q[MAC_LATENCY-1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_loop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv2d_loop_scheduler
//  Purpose  : Directed self-checking bench: padded 3x3 layer and a stride-2 layer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv2d_loop_scheduler;
  localparam int AW  = 20;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic start_drv = 1'b0;
  logic ready_drv = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int c_ic, c_oc, c_ih, c_iw, c_k, c_s, c_p;

  always #5 clk = ~clk;

  conv2d_loop_scheduler_if #(.ADDR_WIDTH(AW)) bus_a ();
  conv2d_loop_scheduler_if #(.ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.start     = start_drv & ~sel;
  assign bus_b.start     = start_drv & sel;
  assign bus_a.mac_ready = ready_drv;
  assign bus_b.mac_ready = ready_drv;

  conv2d_loop_scheduler #(
    .IN_CHANNELS(1), .OUT_CHANNELS(2), .IN_HEIGHT(3), .IN_WIDTH(3),
    .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .MAC_LATENCY(LAT), .ADDR_WIDTH(AW)
  ) u_dut_pad (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  conv2d_loop_scheduler #(
    .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(5), .IN_WIDTH(5),
    .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0), .MAC_LATENCY(LAT), .ADDR_WIDTH(AW)
  ) u_dut_stride (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic          obs_busy, obs_done, obs_valid, obs_wr;
  logic [AW-1:0] obs_out_addr;
  logic [63:0]   obs_term;

  assign obs_busy     = sel ? bus_b.busy      : bus_a.busy;
  assign obs_done     = sel ? bus_b.done      : bus_a.done;
  assign obs_valid    = sel ? bus_b.mac_valid : bus_a.mac_valid;
  assign obs_wr       = sel ? bus_b.out_wr    : bus_a.out_wr;
  assign obs_out_addr = sel ? bus_b.out_addr  : bus_a.out_addr;
  // {pad_zero, mac_clear, mac_last, b_addr, w_addr, in_addr}
  assign obs_term = sel ?
    {1'b0, bus_b.pad_zero, bus_b.mac_clear, bus_b.mac_last, bus_b.b_addr, bus_b.w_addr, bus_b.in_addr} :
    {1'b0, bus_a.pad_zero, bus_a.mac_clear, bus_a.mac_last, bus_a.b_addr, bus_a.w_addr, bus_a.in_addr};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int out_h();
    return (c_ih + 2 * c_p - c_k) / c_s + 1;
  endfunction

  function automatic int out_w();
    return (c_iw + 2 * c_p - c_k) / c_s + 1;
  endfunction

  // Expected term n of the layer, derived from the flat term index.
  function automatic logic [63:0] model_term(input int n);
    int terms, e, kw, kh, ic, ow, oh, oc, ih, iw, in_a, w_a;
    logic pad, clr, lst;
    terms = c_ic * c_k * c_k;
    kw  = n % c_k;
    kh  = (n / c_k) % c_k;
    ic  = (n / (c_k * c_k)) % c_ic;
    e   = n / terms;
    ow  = e % out_w();
    oh  = (e / out_w()) % out_h();
    oc  = e / (out_w() * out_h());
    ih  = oh * c_s + kh - c_p;
    iw  = ow * c_s + kw - c_p;
    pad = (ih < 0) || (ih >= c_ih) || (iw < 0) || (iw >= c_iw);
    in_a = pad ? 0 : (ic * c_ih + ih) * c_iw + iw;
    w_a  = ((oc * c_ic + ic) * c_k + kh) * c_k + kw;
    clr  = (ic == 0) && (kh == 0) && (kw == 0);
    lst  = (ic == c_ic - 1) && (kh == c_k - 1) && (kw == c_k - 1);
    return {1'b0, pad, clr, lst, AW'(oc), AW'(w_a), AW'(in_a)};
  endfunction

  logic [63:0] seen [int];
  int          pad_seen;
  int          wr_count;

  // One layer run; returns at the negedge of the done cycle (or after a reset abort).
  task automatic run_layer(input string name, input logic use_b, input int stall_term,
                           input int stall_len, input int rst_term, input logic hold_start,
                           output int done_k);
    int total, k, n, stalled, wr_idx, busy_bad, quiet_bad, exp_cyc;
    int exp_q[$];
    logic [63:0] exp_t;
    total    = c_oc * out_h() * out_w() * c_ic * c_k * c_k;
    k = 0; n = 0; stalled = 0; wr_idx = 0; busy_bad = 0; done_k = -1;
    pad_seen = 0;
    seen.delete();
    sel = use_b;
    @(negedge clk);
    start_drv = 1'b1;
    ready_drv = 1'b1;
    while (k < total + stall_len + LAT + 20) begin
      @(negedge clk);
      k++;
      if (!hold_start) start_drv = 1'b0;
      if (obs_done) begin
        done_k = k;
        check({name, "_done_busy"}, obs_busy, 0);
        break;
      end
      if (!obs_busy) busy_bad++;
      if (obs_wr) begin
        exp_cyc = -1;
        if (exp_q.size() > 0) exp_cyc = exp_q.pop_front();
        check({name, "_wr_cycle"}, k, exp_cyc);
        check({name, "_wr_addr"}, obs_out_addr, wr_idx);
        wr_idx++;
      end
      if (obs_valid) begin
        exp_t = model_term(n);
        check($sformatf("%s_term%0d", name, n), obs_term, exp_t);
        if (!seen.exists(n)) seen[n] = obs_term;
        if (obs_term[62]) pad_seen++;
        if (n == rst_term) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          start_drv = 1'b0;
          check({name, "_rst_ctrl"}, {obs_busy, obs_done, obs_valid, obs_wr}, 0);
          check({name, "_rst_term"}, obs_term, 0);
          quiet_bad = 0;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (obs_busy || obs_done || obs_valid || obs_wr) quiet_bad++;
          end
          check({name, "_rst_quiet"}, quiet_bad, 0);
          return;
        end
        if (n == stall_term && stalled < stall_len) begin
          ready_drv = 1'b0;
          stalled++;
        end else begin
          ready_drv = 1'b1;
          if (exp_t[60]) exp_q.push_back(k + LAT);
          n++;
        end
      end else begin
        ready_drv = 1'b1;
      end
    end
    check({name, "_done_cycle"}, done_k, total + stall_len + LAT + 1);
    check({name, "_terms"}, n, total);
    check({name, "_busy"}, busy_bad, 0);
    check({name, "_wr_pending"}, exp_q.size(), 0);
    wr_count = wr_idx;
  endtask

  int done_k;

  initial begin
    c_ic = 1; c_oc = 2; c_ih = 3; c_iw = 3; c_k = 3; c_s = 1; c_p = 1;
    repeat (3) @(negedge clk);
    check("reset_a_ctrl", {bus_a.busy, bus_a.done, bus_a.mac_valid, bus_a.mac_clear,
                           bus_a.mac_last, bus_a.pad_zero, bus_a.out_wr}, 0);
    check("reset_a_addr", {bus_a.in_addr, bus_a.w_addr, bus_a.b_addr}, 0);
    check("reset_a_out", bus_a.out_addr, 0);
    check("reset_b_ctrl", {bus_b.busy, bus_b.done, bus_b.mac_valid, bus_b.out_wr}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", {bus_a.busy, bus_a.mac_valid}, 0);

    // Basic padded run
    run_layer("basic", 1'b0, -1, 0, -1, 1'b0, done_k);
    check("basic_done_at_165", done_k, 165);
    check("basic_wr_count", wr_count, 18);
    check("basic_t0_pad", seen[0][62], 1);
    check("basic_t0_clear", seen[0][61], 1);
    check("basic_t0_in", seen[0][19:0], 0);
    check("basic_t4_pad", seen[4][62], 0);
    check("basic_t4_in", seen[4][19:0], 0);
    check("basic_t4_w", seen[4][39:20], 4);
    check("basic_t161_last", seen[161][60], 1);

    // Backpressure at term 40
    run_layer("stall", 1'b0, 40, 3, -1, 1'b0, done_k);
    check("stall_done_at_168", done_k, 168);
    check("stall_wr_count", wr_count, 18);

    // Reset mid-run, then identical restart
    run_layer("rst50", 1'b0, -1, 0, 50, 1'b0, done_k);
    run_layer("restart", 1'b0, -1, 0, -1, 1'b0, done_k);
    check("restart_wr_count", wr_count, 18);
    // Reset while element 4's write is still in the delay line
    run_layer("rst45", 1'b0, -1, 0, 45, 1'b0, done_k);

    // start held high across the whole run and DONE
    run_layer("hold", 1'b0, -1, 0, -1, 1'b1, done_k);
    @(negedge clk);
    check("hold_idle_gap", {obs_busy, obs_valid, obs_done}, 0);
    @(negedge clk);
    check("hold_rerun_valid", obs_valid, 1);
    check("hold_rerun_term0", obs_term, model_term(0));
    start_drv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Stride-2, no padding
    c_ic = 1; c_oc = 1; c_ih = 5; c_iw = 5; c_k = 3; c_s = 2; c_p = 0;
    run_layer("stride", 1'b1, -1, 0, -1, 1'b0, done_k);
    check("stride_done_at_39", done_k, 39);
    check("stride_wr_count", wr_count, 4);
    check("stride_t9_in", seen[9][19:0], 2);
    check("stride_no_pad", pad_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
